// File: rtl/clk_div_bank.sv
// Bank of independent programmable tick/clock-enable dividers with per-channel
// divisor, enable and output mode, plus a global halt and a global re-phase strobe.
module clk_div_bank #(
    parameter int          CHANNELS    = 4,
    parameter int          CNT_W       = 24,
    parameter int unsigned DEFAULT_DIV = 12500000,
    localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic                cfg_mode,
    input  logic                cfg_en,
    output logic [CNT_W-1:0]    rd_div,
    output logic                rd_mode,
    output logic                rd_en,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]    div_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] en_q;
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] wr_sel;
    logic                ch_valid;

    assign ch_valid = (int'(cfg_ch) < CHANNELS);

    always_comb begin
        wr_sel = '0;
        if (cfg_we && ch_valid)
            wr_sel[cfg_ch] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i]  <= DEF_DIV;
                cnt_q[i]  <= '0;
                mode_q[i] <= 1'b0;
                en_q[i]   <= 1'b1;
                out_q[i]  <= 1'b0;
                tick_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_sel[i]) begin
                    div_q[i]  <= cfg_div;
                    mode_q[i] <= cfg_mode;
                    en_q[i]   <= cfg_en;
                    cnt_q[i]  <= '0;
                    out_q[i]  <= 1'b0;
                    tick_q[i] <= 1'b0;
                end else if (halt) begin
                    // sync still re-phases a halted bank so all channels restart together
                    out_q[i]  <= 1'b0;
                    tick_q[i] <= 1'b0;
                    if (sync)
                        cnt_q[i] <= '0;
                end else if (sync || !en_q[i]) begin
                    cnt_q[i]  <= '0;
                    out_q[i]  <= 1'b0;
                    tick_q[i] <= 1'b0;
                end else if (cnt_q[i] == div_q[i]) begin
                    cnt_q[i]  <= '0;
                    tick_q[i] <= 1'b1;
                    out_q[i]  <= mode_q[i] ? 1'b1 : ~out_q[i];
                end else begin
                    cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
                    tick_q[i] <= 1'b0;
                    if (mode_q[i])
                        out_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_div  = '0;
        rd_mode = 1'b0;
        rd_en   = 1'b0;
        if (ch_valid) begin
            rd_div  = div_q[cfg_ch];
            rd_mode = mode_q[cfg_ch];
            rd_en   = en_q[cfg_ch];
        end
    end

    assign out  = out_q;
    assign tick = tick_q;

endmodule
